axi_rd_arbiter: RTL

- Shares one AXI-style read channel (AR + R, no rready) between two read masters: port 0 (weight buffer) and port 1 (input feature-map buffer).
- Round-robin grant per burst; grant is held from address issue until the final data beat.
- Sits between the on-chip buffers and the AXI bus model/interconnect.
- Watchdog flags a burst that exceeds MAX_BEATS without rlast.

---
 rtl/axi_rd_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//   Shares one AXI-style read channel (AR + R, no rready) between two read
//   masters: port 0 (weight buffer) and port 1 (input feature-map buffer).
//   Round-robin grant per burst; the grant is held from address issue until
//   the final data beat. A watchdog flags a burst that runs MAX_BEATS beats
//   without rlast, aborts it and latches a sticky error.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   mX_arvalid/araddr/arburst     per-port read request (X = 0, 1)
//   mX_arready                    per-port address accept (combinational)
//   mX_rvalid/rdata/rlast         per-port read data (combinational pass-through)
//   s_arvalid/araddr/arburst      registered bus address channel
//   s_arready                     bus address accept
//   s_rvalid/rdata/rlast          bus read data
//   grant_id                      port owning the channel (valid while busy)
//   busy                          channel is in ADDR or DATA
//   err                           sticky watchdog error, cleared only by rst
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MAX_BEATS = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_arvalid,
    input  logic [AW-1:0] m0_araddr,
    input  logic [3:0]    m0_arburst,
    output logic          m0_arready,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rlast,
    input  logic          m1_arvalid,
    input  logic [AW-1:0] m1_araddr,
    input  logic [3:0]    m1_arburst,
    output logic          m1_arready,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rlast,
    output logic          s_arvalid,
    output logic [AW-1:0] s_araddr,
    output logic [3:0]    s_arburst,
    input  logic          s_arready,
    input  logic          s_rvalid,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_rlast,
    output logic          grant_id,
    output logic          busy,
    output logic          err
);

    localparam int            CW       = $clog2(MAX_BEATS) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);
    localparam logic [CW-1:0] SAT_CNT  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state_r;
    logic [CW-1:0] beat_cnt_r;
    logic          last_grant_r;

    logic          winner_s;
    logic [AW-1:0] win_addr_s;
    logic [3:0]    win_burst_s;
    logic          data_phase_s;

    // Round-robin pick: a lone requester wins; on a tie the port that did not own the last burst wins.
    always_comb begin
        winner_s = 1'b0;
        if (m0_arvalid && m1_arvalid) begin
            winner_s = ~last_grant_r;
        end else if (m1_arvalid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        win_addr_s  = winner_s ? m1_araddr  : m0_araddr;
        win_burst_s = winner_s ? m1_arburst : m0_arburst;
    end

    assign busy         = (state_r != IDLE);
    assign data_phase_s = (state_r == DATA);

    // Address accept and read-data routing to the granted port only; the other port sees zeros.
    always_comb begin
        m0_arready = (state_r == ADDR) && (grant_id == 1'b0) && s_arready;
        m1_arready = (state_r == ADDR) && (grant_id == 1'b1) && s_arready;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rlast   = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rlast   = 1'b0;
        if (data_phase_s && (grant_id == 1'b0)) begin
            m0_rvalid = s_rvalid;
            m0_rdata  = s_rdata;
            m0_rlast  = s_rlast;
        end else if (data_phase_s && (grant_id == 1'b1)) begin
            m1_rvalid = s_rvalid;
            m1_rdata  = s_rdata;
            m1_rlast  = s_rlast;
        end else begin
            m0_rvalid = 1'b0;
            m1_rvalid = 1'b0;
        end
    end

    // Arbitration FSM with registered bus address channel, beat counter and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            s_arvalid    <= 1'b0;
            s_araddr     <= '0;
            s_arburst    <= 4'd0;
            grant_id     <= 1'b0;
            err          <= 1'b0;
            beat_cnt_r   <= '0;
            last_grant_r <= 1'b1;   // port 0 wins the first tie
        end else begin
            case (state_r)
                IDLE: begin
                    // Bus beats arriving here are strays or leftovers of an aborted burst: dropped.
                    if (m0_arvalid || m1_arvalid) begin
                        s_araddr  <= win_addr_s;
                        s_arburst <= win_burst_s;
                        s_arvalid <= 1'b1;
                        grant_id  <= winner_s;
                        state_r   <= ADDR;
                    end
                end
                ADDR: begin
                    // s_arvalid is always high here, so s_arready alone completes the handshake.
                    if (s_arready) begin
                        s_arvalid  <= 1'b0;
                        beat_cnt_r <= '0;
                        state_r    <= DATA;
                    end
                end
                DATA: begin
                    if (s_rvalid) begin
                        if (beat_cnt_r != SAT_CNT) begin
                            beat_cnt_r <= beat_cnt_r + CW'(1);
                        end
                        if (s_rlast) begin
                            last_grant_r <= grant_id;
                            state_r      <= IDLE;
                        end else if (beat_cnt_r == LAST_CNT) begin
                            // Burst ran out of beats without rlast: abort and latch the error.
                            err          <= 1'b1;
                            last_grant_r <= grant_id;
                            state_r      <= IDLE;
                        end
                    end
                end
                default: begin
                    s_arvalid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
